// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the arbiter's requester, memory-macro and stall signals.
// The slave modport is the arbiter's own view. The master modport is the view
// of the surroundings: the fetch/memory stages and the memory macro.
interface mem_port_arbiter_if #(
   parameter int N = 10
);
   logic          if_req_i;
   logic [N-1:0]  if_addr_i;
   logic [31:0]   if_rdata_o;
   logic          if_ready_o;
   logic          dm_req_i;
   logic          dm_we_i;
   logic [N-1:0]  dm_addr_i;
   logic [31:0]   dm_wdata_i;
   logic [31:0]   dm_rdata_o;
   logic          dm_ready_o;
   logic          mem_en_o;
   logic          mem_we_o;
   logic [N-1:0]  mem_addr_o;
   logic [31:0]   mem_wdata_o;
   logic [31:0]   mem_rdata_i;
   logic          stall_if_o;
   logic          stall_dm_o;
   logic          busy_o;

   modport slave (
      input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
      output if_rdata_o, if_ready_o, dm_rdata_o, dm_ready_o,
             mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
             stall_if_o, stall_dm_o, busy_o
   );

   modport master (
      output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
      input  if_rdata_o, if_ready_o, dm_rdata_o, dm_ready_o,
             mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
             stall_if_o, stall_dm_o, busy_o
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, fixed-latency memory between instruction fetch and
// data memory. The arbiter handles one access at a time. Each access runs
// IDLE -> ACCESS (LAT cycles) -> DONE, and DONE issues a one-cycle ready pulse.
// LAT must lie in 1..15.
// Optional build macro MEM_ARB_RR_EN: round-robin arbitration on simultaneous
// requests. When the macro is not defined, data always wins.
module mem_port_arbiter #(
   parameter int N   = 10,
   parameter int LAT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t        state;
   logic [3:0]    cnt;
   logic          grant_dm;
   logic          pick_dm;
   logic          any_req;
   logic          mem_en_q;
   logic          mem_we_q;
   logic [N-1:0]  mem_addr_q;
   logic [31:0]   mem_wdata_q;
   logic [31:0]   if_rdata_q;
   logic [31:0]   dm_rdata_q;
   logic          if_ready_q;
   logic          dm_ready_q;
   logic          busy_q;

   assign any_req = bus.if_req_i | bus.dm_req_i;

`ifdef MEM_ARB_RR_EN
   logic last_dm;

   // On a tie, serve the requester that was not served last
   always_comb begin
      pick_dm = bus.dm_req_i;
      if (bus.dm_req_i && bus.if_req_i) begin
         pick_dm = ~last_dm;
      end
   end

   // Record who won each grant; the reset value lets data win the first tie
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_dm <= 1'b0;
      end else if (state == IDLE && any_req) begin
         last_dm <= pick_dm;
      end
   end
`else
   // Fixed priority: data wins whenever it asks (it is the older instruction)
   always_comb begin
      pick_dm = bus.dm_req_i;
   end
`endif

   // Access sequencer: latch the winner in IDLE, run the wait-state count,
   // capture read data on the last ACCESS cycle, then pulse ready in DONE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         grant_dm    <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'd0;
         if_rdata_q  <= 32'd0;
         dm_rdata_q  <= 32'd0;
         if_ready_q  <= 1'b0;
         dm_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state       <= ACCESS;
                  busy_q      <= 1'b1;
                  grant_dm    <= pick_dm;
                  cnt         <= 4'(LAT);
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= pick_dm & bus.dm_we_i;
                  mem_addr_q  <= pick_dm ? bus.dm_addr_i : bus.if_addr_i;
                  mem_wdata_q <= bus.dm_wdata_i;
               end
            end
            ACCESS: begin
               if (cnt == 4'd1) begin
                  state    <= DONE;
                  mem_en_q <= 1'b0;
                  mem_we_q <= 1'b0;
                  if (grant_dm) begin
                     dm_ready_q <= 1'b1;
                     if (!mem_we_q) begin
                        dm_rdata_q <= bus.mem_rdata_i;
                     end
                  end else begin
                     if_ready_q <= 1'b1;
                     if_rdata_q <= bus.mem_rdata_i;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               state      <= IDLE;
               busy_q     <= 1'b0;
               if_ready_q <= 1'b0;
               dm_ready_q <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_en_o    = mem_en_q;
   assign bus.mem_we_o    = mem_we_q;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_wdata_o = mem_wdata_q;
   assign bus.if_rdata_o  = if_rdata_q;
   assign bus.dm_rdata_o  = dm_rdata_q;
   assign bus.if_ready_o  = if_ready_q;
   assign bus.dm_ready_o  = dm_ready_q;
   assign bus.busy_o      = busy_q;
   assign bus.stall_if_o  = bus.if_req_i & ~if_ready_q;
   assign bus.stall_dm_o  = bus.dm_req_i & ~dm_ready_q;
endmodule
